// File: rtl/tlb_walker_pkg.sv
// Shared types for the MMU page-table walker: address/PTE formats, walk states,
// requester encoding and the PTE address helper.
package tlb_walker_pkg;

    typedef logic [19:0] pptr_t;
    typedef logic [19:0] vpn_t;
    typedef logic [7:0]  ppn_t;

    typedef struct packed {
        logic        valid;
        logic [22:0] reserved;
        ppn_t        ppn;
    } pte_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        FAULT
    } walk_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } tlb_src_t;

    // PTEs are 4 bytes; the sum deliberately wraps inside the 20-bit physical space.
    function automatic pptr_t pte_addr(input pptr_t base, input vpn_t vpn);
        return base + {vpn[17:0], 2'b00};
    endfunction

endpackage

// File: rtl/tlb_walker_rr_arb2.sv
// Two-way round-robin arbiter between the itlb and dtlb miss lines.
// last_grant resets to dtlb so the itlb wins the first tie.
module rr_arb2
    import tlb_walker_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     req_i,
    input  logic     req_d,
    output logic     gnt,
    output tlb_src_t gnt_src
);

    tlb_src_t last_grant;

    always_comb begin
        gnt     = en && (req_i || req_d);
        gnt_src = SRC_I;
        if (req_i && req_d) begin
            gnt_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
        end else if (req_d) begin
            gnt_src = SRC_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_D;
        end else if (gnt) begin
            last_grant <= gnt_src;
        end
    end

endmodule

// File: rtl/tlb_walker.sv
// Shared single-level page-table walker: arbitrates itlb/dtlb misses, reads the
// PTE and either refills the missing TLB or raises a page fault.
//
// state | meaning
// IDLE  | no walk; arbitrate pending misses
// REQ   | PTE read request held until mem_gnt
// WAIT  | waiting for mem_rvalid
// FILL  | one-cycle write strobe to the granted TLB
// FAULT | invalid PTE; fault held until fault_ack
module tlb_walker
    import tlb_walker_pkg::*;
#(
    parameter int PTE_W     = 32,
    parameter int PTE_V_BIT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  pptr_t            ptbr,
    input  logic             itlb_miss,
    input  vpn_t             itlb_vpn,
    output logic             itlb_write_en,
    output vpn_t             itlb_write_vpn,
    output ppn_t             itlb_write_ppn,
    input  logic             dtlb_miss,
    input  vpn_t             dtlb_vpn,
    output logic             dtlb_write_en,
    output vpn_t             dtlb_write_vpn,
    output ppn_t             dtlb_write_ppn,
    output logic             mem_req,
    output pptr_t            mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [PTE_W-1:0] mem_rdata,
    output logic             fault,
    output logic             fault_src,
    output vpn_t             fault_vpn,
    input  logic             fault_ack,
    output logic             busy
);

    walk_state_t state, state_nxt;
    tlb_src_t    src_q;
    vpn_t        vpn_q;
    ppn_t        ppn_q;
    logic        arb_gnt;
    tlb_src_t    arb_src;
    pte_t        pte_w;
    logic        unused_pte;

    assign pte_w      = pte_t'(mem_rdata);
    assign unused_pte = ^{pte_w.valid, pte_w.reserved};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state == IDLE),
        .req_i   (itlb_miss),
        .req_d   (dtlb_miss),
        .gnt     (arb_gnt),
        .gnt_src (arb_src)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            src_q <= SRC_I;
            vpn_q <= '0;
            ppn_q <= '0;
        end else begin
            state <= state_nxt;
            if (arb_gnt) begin
                src_q <= arb_src;
                vpn_q <= (arb_src == SRC_D) ? dtlb_vpn : itlb_vpn;
            end
            if (state == WAIT && mem_rvalid) begin
                ppn_q <= pte_w.ppn;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_gnt) state_nxt = REQ;
            REQ:     if (mem_gnt) state_nxt = WAIT;
            WAIT:    if (mem_rvalid) state_nxt = mem_rdata[PTE_V_BIT] ? FILL : FAULT;
            FILL:    state_nxt = IDLE;
            FAULT:   if (fault_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs decode from registered state so misses never reach mem_req combinationally.
    assign busy     = (state != IDLE);
    assign mem_req  = (state == REQ);
    assign mem_addr = (state == REQ) ? pte_addr(ptbr, vpn_q) : '0;

    assign itlb_write_en  = (state == FILL) && (src_q == SRC_I);
    assign itlb_write_vpn = itlb_write_en ? vpn_q : '0;
    assign itlb_write_ppn = itlb_write_en ? ppn_q : '0;
    assign dtlb_write_en  = (state == FILL) && (src_q == SRC_D);
    assign dtlb_write_vpn = dtlb_write_en ? vpn_q : '0;
    assign dtlb_write_ppn = dtlb_write_en ? ppn_q : '0;

    assign fault     = (state == FAULT);
    assign fault_src = fault && (src_q == SRC_D);
    assign fault_vpn = fault ? vpn_q : '0;

endmodule

// File: tb/tb_tlb_walker.sv
// Directed bench for tlb_walker: inputs change and outputs are sampled on the falling edge.
module tb_tlb_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] ptbr;
    logic        itlb_miss;
    logic [19:0] itlb_vpn;
    logic        itlb_write_en;
    logic [19:0] itlb_write_vpn;
    logic [7:0]  itlb_write_ppn;
    logic        dtlb_miss;
    logic [19:0] dtlb_vpn;
    logic        dtlb_write_en;
    logic [19:0] dtlb_write_vpn;
    logic [7:0]  dtlb_write_ppn;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fault;
    logic        fault_src;
    logic [19:0] fault_vpn;
    logic        fault_ack;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlb_walker dut (
        .clk            (clk),
        .rst            (rst),
        .ptbr           (ptbr),
        .itlb_miss      (itlb_miss),
        .itlb_vpn       (itlb_vpn),
        .itlb_write_en  (itlb_write_en),
        .itlb_write_vpn (itlb_write_vpn),
        .itlb_write_ppn (itlb_write_ppn),
        .dtlb_miss      (dtlb_miss),
        .dtlb_vpn       (dtlb_vpn),
        .dtlb_write_en  (dtlb_write_en),
        .dtlb_write_vpn (dtlb_write_vpn),
        .dtlb_write_ppn (dtlb_write_ppn),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .fault          (fault),
        .fault_src      (fault_src),
        .fault_vpn      (fault_vpn),
        .fault_ack      (fault_ack),
        .busy           (busy)
    );

    task automatic reset_dut();
        rst = 1'b1;
        ptbr = '0; itlb_miss = 1'b0; itlb_vpn = '0; dtlb_miss = 1'b0; dtlb_vpn = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; fault_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // From a REQ-cycle falling edge: immediate grant, data one cycle later; returns in FILL/FAULT.
    task automatic mem_cycle(input logic [31:0] rdata);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ptbr = '0; itlb_miss = 1'b0; itlb_vpn = '0; dtlb_miss = 1'b0; dtlb_vpn = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; fault_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, mem_req, fault, fault_src, itlb_write_en, dtlb_write_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy/req/fault/src/iwe/dwe=%b expected 000000",
                     {busy, mem_req, fault, fault_src, itlb_write_en, dtlb_write_en});
        end
        checks++;
        if (fault_vpn !== 20'h0) begin
            errors++;
            $display("FAIL reset_fault_vpn: got %h expected 00000", fault_vpn);
        end
        itlb_miss = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_holds_idle: got busy=%b mem_req=%b expected 0 0", busy, mem_req);
        end
        itlb_miss = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        reset_dut();
        ptbr = 20'h40000; itlb_vpn = 20'h00012; itlb_miss = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'h40048 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_req: got req=%b addr=%h busy=%b expected 1 40048 1", mem_req, mem_addr, busy);
        end
        itlb_vpn = 20'h00999;
        mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_req_drop: got mem_req=%b expected 0", mem_req);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80000037;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        checks++;
        if (itlb_write_en !== 1'b1 || itlb_write_vpn !== 20'h00012 || itlb_write_ppn !== 8'h37) begin
            errors++;
            $display("FAIL basic_fill: got we=%b vpn=%h ppn=%h expected 1 00012 37",
                     itlb_write_en, itlb_write_vpn, itlb_write_ppn);
        end
        checks++;
        if (dtlb_write_en !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL basic_other_quiet: got dtlb_we=%b fault=%b expected 0 0", dtlb_write_en, fault);
        end
        itlb_miss = 1'b0;
        @(negedge clk);
        checks++;
        if (itlb_write_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse: got we=%b busy=%b expected 0 0", itlb_write_en, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_rewalk: got busy=%b req=%b expected 0 0", busy, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        ptbr = 20'h00000;
        itlb_vpn = 20'h00111; dtlb_vpn = 20'h00222;
        itlb_miss = 1'b1; dtlb_miss = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_addr !== 20'h00444) begin
            errors++;
            $display("FAIL tie1_itlb_first: got addr=%h expected 00444", mem_addr);
        end
        mem_cycle(32'h80000011);
        checks++;
        if (itlb_write_en !== 1'b1 || dtlb_write_en !== 1'b0 || itlb_write_ppn !== 8'h11) begin
            errors++;
            $display("FAIL tie1_fill: got iwe=%b dwe=%b ppn=%h expected 1 0 11",
                     itlb_write_en, dtlb_write_en, itlb_write_ppn);
        end
        itlb_vpn = 20'h00333;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== 20'h00888) begin
            errors++;
            $display("FAIL tie2_dtlb_first: got addr=%h expected 00888", mem_addr);
        end
        mem_cycle(32'h80000022);
        checks++;
        if (dtlb_write_en !== 1'b1 || itlb_write_en !== 1'b0 ||
            dtlb_write_vpn !== 20'h00222 || dtlb_write_ppn !== 8'h22) begin
            errors++;
            $display("FAIL tie2_fill: got dwe=%b iwe=%b vpn=%h ppn=%h expected 1 0 00222 22",
                     dtlb_write_en, itlb_write_en, dtlb_write_vpn, dtlb_write_ppn);
        end
        dtlb_miss = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== 20'h00ccc) begin
            errors++;
            $display("FAIL tie2_itlb_next: got addr=%h expected 00ccc", mem_addr);
        end
        mem_cycle(32'h80000033);
        checks++;
        if (itlb_write_en !== 1'b1 || itlb_write_vpn !== 20'h00333 || itlb_write_ppn !== 8'h33) begin
            errors++;
            $display("FAIL tie2_itlb_fill: got we=%b vpn=%h ppn=%h expected 1 00333 33",
                     itlb_write_en, itlb_write_vpn, itlb_write_ppn);
        end
        itlb_miss = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fault();
        reset_dut();
        ptbr = 20'h40000; dtlb_vpn = 20'h0ABCD; dtlb_miss = 1'b1;
        @(negedge clk);
        mem_cycle(32'h00000055);
        dtlb_miss = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fault !== 1'b1 || fault_src !== 1'b1 || fault_vpn !== 20'h0ABCD) begin
                errors++;
                $display("FAIL fault_hold[%0d]: got fault=%b src=%b vpn=%h expected 1 1 0abcd",
                         i, fault, fault_src, fault_vpn);
            end
            checks++;
            if (itlb_write_en !== 1'b0 || dtlb_write_en !== 1'b0) begin
                errors++;
                $display("FAIL fault_no_write[%0d]: got iwe=%b dwe=%b expected 0 0", i, itlb_write_en, dtlb_write_en);
            end
            @(negedge clk);
        end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b0 || fault_src !== 1'b0) begin
            errors++;
            $display("FAIL fault_ack: got fault=%b busy=%b src=%b expected 0 0 0", fault, busy, fault_src);
        end
        fault_ack = 1'b1;
        @(negedge clk);
        fault_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: got busy=%b fault=%b expected 0 0", busy, fault);
        end
    endtask

    task automatic test_gnt_delay();
        reset_dut();
        ptbr = 20'h10000; itlb_vpn = 20'h00100; itlb_miss = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 20'h10400) begin
                errors++;
                $display("FAIL gnt_delay_hold[%0d]: got req=%b addr=%h expected 1 10400", i, mem_req, mem_addr);
            end
            mem_gnt = (i == 3);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gnt_delay_drop: got req=%b busy=%b expected 0 1", mem_req, busy);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h800000A5;
        @(negedge clk);
        mem_rvalid = 1'b0;
        checks++;
        if (itlb_write_en !== 1'b1 || itlb_write_ppn !== 8'hA5) begin
            errors++;
            $display("FAIL gnt_delay_fill: got we=%b ppn=%h expected 1 a5", itlb_write_en, itlb_write_ppn);
        end
        itlb_miss = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        reset_dut();
        ptbr = 20'hFFFF0; dtlb_vpn = 20'h00008; dtlb_miss = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_addr !== 20'h00010 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL addr_wrap: got addr=%h req=%b expected 00010 1", mem_addr, mem_req);
        end
        mem_cycle(32'hFFFFFF7E);
        checks++;
        if (dtlb_write_en !== 1'b1 || dtlb_write_vpn !== 20'h00008 || dtlb_write_ppn !== 8'h7E) begin
            errors++;
            $display("FAIL wrap_fill: got we=%b vpn=%h ppn=%h expected 1 00008 7e",
                     dtlb_write_en, dtlb_write_vpn, dtlb_write_ppn);
        end
        dtlb_miss = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        reset_dut();
        ptbr = 20'h40000; itlb_vpn = 20'h00044; itlb_miss = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        itlb_miss = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle: got busy=%b req=%b expected 0 0", busy, mem_req);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h800000AA;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        checks++;
        if (itlb_write_en !== 1'b0 || dtlb_write_en !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_abandon: got iwe=%b dwe=%b fault=%b busy=%b expected 0 0 0 0",
                     itlb_write_en, dtlb_write_en, fault, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_fill();
        test_back_to_back();
        test_fault();
        test_gnt_delay();
        test_addr_wrap();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
